timer_sched: RTL

Round-robin scheduler that time-shares one 16-bit one-shot timer among `NREQ` requesters. Each requester posts a period. The scheduler grants the timer to one requester at a time, clears and starts the timer, waits for expiry, then raises a sticky per-requester interrupt. It sits between the peripheral control/register layer and the single timer instance, and is the only driver of the timer's control inputs.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/timer_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer scheduler slice.
//   state_t      - scheduler FSM states (binary encoded)
//   PW_DEFAULT   - default period / counter width
//   CTRL_*_BIT   - control-register bit positions used by the register layer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PW_DEFAULT = 16;

  localparam int CTRL_START_BIT   = 2;
  localparam int CTRL_ENABLE_BIT  = 3;
  localparam int CTRL_IRQ_BIT     = 5;
  localparam int CTRL_CNT_RST_BIT = 7;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   eligible [NREQ] - requesters that may be granted
//   last     [IW]   - index of the most recent owner; search starts at last+1
//   pick     [NREQ] - one-hot winner (0 when nobody is eligible)
//   any             - at least one requester is eligible
module rr_arbiter
  import timer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
)
(
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  logic [IW-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    // Walk the ring once, starting just after the previous owner; the
    // first eligible slot wins, which also covers wrap-around.
    for (int off = 1; off <= NREQ; off++) begin
      idx = IW'((int'(last) + off) % NREQ);
      if (!any && eligible[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: time-shares one one-shot timer among NREQ requesters.
//   clk        - system / timer clock
//   rst        - asynchronous active-low reset
//   req        - level request per requester
//   period_in  - packed periods, slice i = period_in[i*PW +: PW]
//   irq_ack    - one-cycle pulses clearing irq bits
//   tmr_expire - timer expiry level (counter == period)
//   tmr_clr    - synchronous clear to the timer
//   tmr_start  - timer count enable
//   tmr_period - period driven to the timer
//   grant      - one-hot current owner, 0 when idle
//   irq        - sticky completion flags
//   busy       - scheduler is not idle
module timer_sched
  import timer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = PW_DEFAULT
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*PW-1:0] period_in,
  input  logic [NREQ-1:0]    irq_ack,
  input  logic               tmr_expire,
  output logic               tmr_clr,
  output logic               tmr_start,
  output logic [PW-1:0]      tmr_period,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    irq,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_next;
  logic            complete, complete_next;
  logic [NREQ-1:0] req_q;
  logic [IW-1:0]   last, gidx, pick_idx;
  logic [NREQ-1:0] eligible, pick, irq_set;
  logic            any;
  logic [PW-1:0]   pick_period;

  // Grant decisions use the registered request, which places the grant one
  // edge after the request is first sampled. Cancel during RUN looks at the
  // live request so the owner can abort with minimum delay.
  assign eligible = req_q & ~irq;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .eligible (eligible),
    .last     (last),
    .pick     (pick),
    .any      (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  assign pick_period = period_in[int'(pick_idx)*PW +: PW];

  always_comb begin
    state_next    = state;
    complete_next = complete;
    case (state)
      IDLE: begin
        if (any) begin
          state_next    = LOAD;
          complete_next = 1'b0;
        end
      end
      LOAD: begin
        // A zero period finishes immediately as a completed timing.
        if (tmr_period == '0) begin
          state_next    = DONE;
          complete_next = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Expiry is checked first so it beats a same-cycle cancel.
        if (tmr_expire) begin
          state_next    = DONE;
          complete_next = 1'b1;
        end else if (!req[gidx]) begin
          state_next    = DONE;
          complete_next = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign irq_set = (state == DONE && complete) ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      complete   <= 1'b0;
      req_q      <= '0;
      last       <= IW'(NREQ - 1);
      gidx       <= '0;
      grant      <= '0;
      irq        <= '0;
      tmr_clr    <= 1'b0;
      tmr_start  <= 1'b0;
      tmr_period <= '0;
      busy       <= 1'b0;
    end else begin
      state    <= state_next;
      complete <= complete_next;
      req_q    <= req;
      // Set is OR-ed after the ack mask so a colliding set wins.
      irq      <= (irq & ~irq_ack) | irq_set;
      // Outputs are registered copies of what the next state implies.
      tmr_clr   <= (state_next == LOAD) || (state_next == DONE);
      tmr_start <= (state_next == RUN);
      busy      <= (state_next != IDLE);
      if (state == IDLE && any) begin
        grant      <= pick;
        gidx       <= pick_idx;
        tmr_period <= pick_period;
      end
      if (state == DONE) begin
        grant <= '0;
        last  <= gidx;
      end
    end
  end

endmodule
